// File: rtl/pipeline_control_unit_pkg.sv
// Shared encodings and control-bundle types for the pipelined MIPS control unit.
package pipeline_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_AND   = 2'b11;

    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       reg_dst;
    } ctrl_t;

    // Later stages only carry the fields still consumed downstream.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

endpackage

// File: rtl/pipeline_control_unit_if.sv
// ID-stage inputs and datapath control outputs of the pipeline control unit.
interface pipeline_control_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int OPCODE_W   = 6
);
    logic [OPCODE_W-1:0]   id_opcode;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_equal;

    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic [1:0] pc_src;
    logic       ex_alu_src;
    logic [1:0] ex_alu_op;
    logic       ex_reg_dst;
    logic       mem_mem_read;
    logic       mem_mem_write;
    logic       wb_reg_write;
    logic       wb_mem_to_reg;
    logic       stall;
    logic       illegal_op;

    modport master (
        output id_opcode, id_rs, id_rt, id_rd, id_equal,
        input  pc_write, ifid_write, ifid_flush, pc_src,
               ex_alu_src, ex_alu_op, ex_reg_dst,
               mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg,
               stall, illegal_op
    );

    modport slave (
        input  id_opcode, id_rs, id_rt, id_rd, id_equal,
        output pc_write, ifid_write, ifid_flush, pc_src,
               ex_alu_src, ex_alu_op, ex_reg_dst,
               mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg,
               stall, illegal_op
    );
endinterface

// File: rtl/pipeline_control_unit_decoder.sv
// Combinational opcode decode: control bundle, illegal flag, rt usage and branch/jump kind.
module ctrl_decoder
    import pipeline_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter bit EN_BNE   = 1'b1
) (
    input  logic [OPCODE_W-1:0] i_opcode,
    output ctrl_t               o_ctrl,
    output logic                o_illegal,
    output logic                o_uses_rt,
    output logic                o_is_beq,
    output logic                o_is_bne,
    output logic                o_is_j
);

    always_comb begin
        o_ctrl    = '0;
        o_illegal = 1'b0;
        o_uses_rt = 1'b0;
        o_is_beq  = 1'b0;
        o_is_bne  = 1'b0;
        o_is_j    = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = ALUOP_FUNCT;
                o_ctrl.reg_dst   = 1'b1;
                o_uses_rt        = 1'b1;
            end
            OP_ADDI: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            OP_ANDI: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.alu_op    = ALUOP_AND;
            end
            OP_LW: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.alu_op     = ALUOP_ADD;
            end
            OP_SW: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_uses_rt        = 1'b1;
            end
            OP_BEQ: begin
                o_ctrl.alu_op = ALUOP_SUB;
                o_uses_rt     = 1'b1;
                o_is_beq      = 1'b1;
            end
            OP_BNE: begin
                // With bne disabled the opcode falls back to the illegal path.
                if (EN_BNE) begin
                    o_ctrl.alu_op = ALUOP_SUB;
                    o_uses_rt     = 1'b1;
                    o_is_bne      = 1'b1;
                end else begin
                    o_illegal = 1'b1;
                end
            end
            OP_J: begin
                o_is_j = 1'b1;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipelined control unit: ID decode, ID/EX/MEM/WB control registers, hazard stalls and ID-stage branch resolution.
module pipeline_control_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int OPCODE_W     = 6,
    parameter bit EN_BNE       = 1'b1,
    parameter bit BR_HAZ_STALL = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    pipeline_control_unit_if.slave   bus
);

    ctrl_t                 w_id_ctrl;
    logic                  w_illegal;
    logic                  w_uses_rt;
    logic                  w_is_beq;
    logic                  w_is_bne;
    logic                  w_is_j;
    logic [REG_ADDR_W-1:0] w_id_dest;
    logic                  w_load_use;
    logic                  w_ex_hit;
    logic                  w_mem_hit;
    logic                  w_br_haz;
    logic                  w_stall;
    logic                  w_taken;

    ctrl_t                 r_ex_ctrl;
    logic [REG_ADDR_W-1:0] r_ex_rt;
    logic [REG_ADDR_W-1:0] r_ex_dest;
    mem_ctrl_t             r_mem_ctrl;
    logic [REG_ADDR_W-1:0] r_mem_dest;
    wb_ctrl_t              r_wb_ctrl;
    logic                  r_illegal;

    ctrl_decoder #(
        .OPCODE_W (OPCODE_W),
        .EN_BNE   (EN_BNE)
    ) u_decoder (
        .i_opcode  (bus.id_opcode),
        .o_ctrl    (w_id_ctrl),
        .o_illegal (w_illegal),
        .o_uses_rt (w_uses_rt),
        .o_is_beq  (w_is_beq),
        .o_is_bne  (w_is_bne),
        .o_is_j    (w_is_j)
    );

    assign w_id_dest = w_id_ctrl.reg_dst ? bus.id_rd : bus.id_rt;

    // $0 is hard-wired, so a match on register zero is never a hazard.
    assign w_load_use = r_ex_ctrl.mem_read && (r_ex_rt != '0) &&
                        ((r_ex_rt == bus.id_rs) || (w_uses_rt && (r_ex_rt == bus.id_rt)));

    assign w_ex_hit  = r_ex_ctrl.reg_write && (r_ex_dest != '0) &&
                       ((r_ex_dest == bus.id_rs) || (r_ex_dest == bus.id_rt));
    assign w_mem_hit = r_mem_ctrl.mem_read && (r_mem_dest != '0) &&
                       ((r_mem_dest == bus.id_rs) || (r_mem_dest == bus.id_rt));
    assign w_br_haz  = BR_HAZ_STALL && (w_is_beq || w_is_bne) && (w_ex_hit || w_mem_hit);

    assign w_stall = w_load_use || w_br_haz;
    assign w_taken = (w_is_beq && bus.id_equal) || (w_is_bne && !bus.id_equal);

    // A stalled branch or jump must not redirect the PC until its operands are ready.
    always_comb begin
        bus.pc_write   = !w_stall;
        bus.ifid_write = !w_stall;
        bus.pc_src     = PCSRC_SEQ;
        bus.ifid_flush = 1'b0;
        if (!w_stall) begin
            if (w_is_j) begin
                bus.pc_src     = PCSRC_JUMP;
                bus.ifid_flush = 1'b1;
            end else if (w_taken) begin
                bus.pc_src     = PCSRC_BRANCH;
                bus.ifid_flush = 1'b1;
            end
        end
    end

    assign bus.stall         = w_stall;
    assign bus.ex_alu_src    = r_ex_ctrl.alu_src;
    assign bus.ex_alu_op     = r_ex_ctrl.alu_op;
    assign bus.ex_reg_dst    = r_ex_ctrl.reg_dst;
    assign bus.mem_mem_read  = r_mem_ctrl.mem_read;
    assign bus.mem_mem_write = r_mem_ctrl.mem_write;
    assign bus.wb_reg_write  = r_wb_ctrl.reg_write;
    assign bus.wb_mem_to_reg = r_wb_ctrl.mem_to_reg;
    assign bus.illegal_op    = r_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_ctrl  <= '0;
            r_ex_rt    <= '0;
            r_ex_dest  <= '0;
            r_mem_ctrl <= '0;
            r_mem_dest <= '0;
            r_wb_ctrl  <= '0;
            r_illegal  <= 1'b0;
        end else begin
            if (w_stall) begin
                r_ex_ctrl <= '0;
                r_ex_rt   <= '0;
                r_ex_dest <= '0;
            end else begin
                r_ex_ctrl <= w_id_ctrl;
                r_ex_rt   <= bus.id_rt;
                r_ex_dest <= w_id_dest;
            end
            r_mem_ctrl <= '{reg_write:  r_ex_ctrl.reg_write,
                            mem_to_reg: r_ex_ctrl.mem_to_reg,
                            mem_read:   r_ex_ctrl.mem_read,
                            mem_write:  r_ex_ctrl.mem_write};
            r_mem_dest <= r_ex_dest;
            r_wb_ctrl  <= '{reg_write:  r_mem_ctrl.reg_write,
                            mem_to_reg: r_mem_ctrl.mem_to_reg};
            r_illegal  <= r_illegal | w_illegal;
        end
    end

endmodule
